inert_spi_serf: RTL and testbench

//  Synthesizable SPI serf emulating the e-bike inertial sensor, i.e. the responder end of the inertial SPI link.

---
 rtl/inert_spi_serf_pkg.sv | 29 ++
 rtl/inert_spi_serf_if.sv | 13 +
 rtl/inert_spi_serf_synch.sv | 28 ++
 rtl/inert_spi_serf.sv | 184 ++++++++++++++++++
 tb/tb_inert_spi_serf.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/inert_spi_serf_pkg.sv
// Package for the inertial-sensor SPI serf.
// Holds register addresses, STATUS bit positions, the WHOAMI default
// and the frame FSM state type.
package inert_serf_pkg;

    localparam logic [6:0] INT1_CTRL = 7'h0D;
    localparam logic [6:0] WHO_AM_I  = 7'h0F;
    localparam logic [6:0] CTRL1_XL  = 7'h10;
    localparam logic [6:0] CTRL2_G   = 7'h11;
    localparam logic [6:0] CTRL5_C   = 7'h14;
    localparam logic [6:0] STATUS    = 7'h1E;
    localparam logic [6:0] ROLL_L    = 7'h24;
    localparam logic [6:0] ROLL_H    = 7'h25;
    localparam logic [6:0] YAW_L     = 7'h26;
    localparam logic [6:0] YAW_H     = 7'h27;
    localparam logic [6:0] AY_L      = 7'h2A;
    localparam logic [6:0] AY_H      = 7'h2B;
    localparam logic [6:0] AZ_L      = 7'h2C;
    localparam logic [6:0] AZ_H      = 7'h2D;

    localparam int ST_XLDA = 0;
    localparam int ST_GDA  = 1;
    localparam int ST_OVR  = 2;

    localparam logic [7:0] WHOAMI_DFLT = 8'h6A;

    typedef enum logic [1:0] {IDLE_WAIT, IDLE, SHIFT} serf_state_t;

endpackage

// File: rtl/inert_spi_serf_if.sv
// SPI pin bundle between the bus master (bench / host) and the serf.
//   SS_n, SCLK, MOSI : master -> serf
//   MISO, INT        : serf -> master
interface inert_spi_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS_n, SCLK, MOSI, input MISO, INT);
    modport slave  (input SS_n, SCLK, MOSI, output MISO, INT);
endinterface

// File: rtl/inert_spi_serf_synch.sv
// spi_edge_synch: SYNC_STAGES-flop synchronizer for one asynchronous pin,
// plus single-cycle rise/fall pulses derived from the synchronized value.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise/fall: one-clk pulses on synchronized edges
module spi_edge_synch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    // Top bit is the previous synchronized value, used only for edge detect.
    logic [SYNC_STAGES:0] sh;

    always_ff @(posedge clk) begin
        if (rst) sh <= '0;
        else     sh <= {sh[SYNC_STAGES-1:0], d};
    end

    assign q    = sh[SYNC_STAGES-1];
    assign rise =  q & ~sh[SYNC_STAGES];
    assign fall = ~q &  sh[SYNC_STAGES];
endmodule

// File: rtl/inert_spi_serf.sv
// inert_spi_serf: SPI responder emulating the e-bike inertial sensor.
// 16-bit frames {R/W, addr[6:0], wdata[7:0]}; read data returns on MISO in
// the low byte of the same frame. Holds four config regs and serves
// roll/yaw/AY/AZ samples captured from parallel inputs; INT flags new data.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   spi          : SPI pins (slave modport), SCLK idles high
//   smpl_vld     : strobe, sample inputs hold a new value
//   roll_rt, yaw_rt, AY, AZ : 16-bit sample inputs
//   cfg_done     : every config reg written at least once since reset
// Build option: define INERT_SERF_OVR_EN to get a sticky overrun bit in
// STATUS[2]; otherwise it reads 0 and no overrun logic exists.
module inert_spi_serf
    import inert_serf_pkg::*;
#(
    parameter logic [7:0] WHOAMI      = WHOAMI_DFLT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    inert_spi_serf_if.slave   spi,
    input  logic              smpl_vld,
    input  logic [15:0]       roll_rt,
    input  logic [15:0]       yaw_rt,
    input  logic [15:0]       AY,
    input  logic [15:0]       AZ,
    output logic              cfg_done
);
    serf_state_t state_q, state_d;

    logic ss_s, ss_rise, ss_fall, sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_edge_synch #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .rst(rst), .d(spi.SS_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_edge_synch #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .d(spi.SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_synch #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .d(spi.MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_edges;
    assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

    logic [4:0]  bit_cnt;
    logic [7:0]  rx;          // after 16 rises this holds wdata
    logic [6:0]  addr_q;
    logic        rw_q;
    logic        ld_tx;
    logic [7:0]  tx;
    logic        miso_q;
    logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5_c;
    logic [3:0]  wr_seen;
    logic [63:0] smp_q, pend_q; // {AZ, AY, yaw, roll}
    logic        pend_vld;
    logic        xlda, gda, int_q, ovr;
    logic [7:0]  rd_byte;

    // Frame-level events; all side effects wait for a full 16-bit frame.
    logic frame_end, wr_ok, clr_dr, clr_st;
    logic commit_now, commit_pend, commit;
    assign frame_end   = (state_q == SHIFT) && ss_rise && (bit_cnt == 5'd16);
    assign wr_ok       = frame_end && !rw_q;
    assign clr_dr      = frame_end && rw_q && (addr_q == AZ_H);
    assign clr_st      = frame_end && rw_q && (addr_q == STATUS);
    assign commit_now  = smpl_vld && (state_q == IDLE);
    assign commit_pend = pend_vld && (state_q == IDLE) && !smpl_vld;
    assign commit      = commit_now || pend_vld && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_WAIT: if (ss_s)    state_d = IDLE;
            IDLE:      if (ss_fall) state_d = SHIFT;
            SHIFT:     if (ss_rise) state_d = IDLE;
            default:                state_d = IDLE_WAIT;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr_q)
            INT1_CTRL: rd_byte = int1_ctrl;
            WHO_AM_I:  rd_byte = WHOAMI;
            CTRL1_XL:  rd_byte = ctrl1_xl;
            CTRL2_G:   rd_byte = ctrl2_g;
            CTRL5_C:   rd_byte = ctrl5_c;
            STATUS:    rd_byte = {5'b0, ovr, gda, xlda};
            ROLL_L:    rd_byte = smp_q[7:0];
            ROLL_H:    rd_byte = smp_q[15:8];
            YAW_L:     rd_byte = smp_q[23:16];
            YAW_H:     rd_byte = smp_q[31:24];
            AY_L:      rd_byte = smp_q[39:32];
            AY_H:      rd_byte = smp_q[47:40];
            AZ_L:      rd_byte = smp_q[55:48];
            AZ_H:      rd_byte = smp_q[63:56];
            default:   rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;  rx       <= '0;  addr_q   <= '0;  rw_q     <= 1'b0;
            ld_tx    <= 1'b0; tx      <= '0;  miso_q   <= 1'b0;
            int1_ctrl <= '0; ctrl1_xl <= '0;  ctrl2_g  <= '0;  ctrl5_c  <= '0;
            wr_seen  <= '0;  smp_q    <= '0;  pend_q   <= '0;  pend_vld <= 1'b0;
            xlda     <= 1'b0; gda     <= 1'b0; int_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && ss_fall) begin
                bit_cnt <= '0;
            end else if (state_q == SHIFT && sclk_rise) begin
                rx      <= {rx[6:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd7) begin
                    addr_q <= {rx[5:0], mosi_s};
                    rw_q   <= rx[6];
                end
            end

            // Response byte loads the clk after the 8th rise, well ahead of
            // the next SCLK fall given the minimum SCLK half-period.
            ld_tx <= (state_q == SHIFT) && sclk_rise && (bit_cnt == 5'd7);
            if (state_q != SHIFT)    tx <= '0;
            else if (ld_tx)          tx <= rw_q ? rd_byte : 8'h00;
            else if (sclk_fall)      tx <= {tx[6:0], 1'b0};

            if (state_q != SHIFT)    miso_q <= 1'b0;
            else if (sclk_fall)      miso_q <= tx[7];

            if (wr_ok) begin
                case (addr_q)
                    INT1_CTRL: begin int1_ctrl <= rx; wr_seen[0] <= 1'b1; end
                    CTRL1_XL:  begin ctrl1_xl  <= rx; wr_seen[1] <= 1'b1; end
                    CTRL2_G:   begin ctrl2_g   <= rx; wr_seen[2] <= 1'b1; end
                    CTRL5_C:   begin ctrl5_c   <= rx; wr_seen[3] <= 1'b1; end
                    default: ;
                endcase
            end

            // Samples arriving mid-frame park here; the newest one wins.
            if (smpl_vld && state_q != IDLE) begin
                pend_q   <= {AZ, AY, yaw_rt, roll_rt};
                pend_vld <= 1'b1;
            end else if (state_q == IDLE) begin
                pend_vld <= 1'b0;
            end

            if (commit) smp_q <= commit_pend ? pend_q : {AZ, AY, yaw_rt, roll_rt};

            // Commit has priority over the clear-on-read of AZ_H.
            if (commit) begin
                xlda <= 1'b1;
                gda  <= 1'b1;
                if (int1_ctrl[1]) int_q <= 1'b1;
                else if (clr_dr)  int_q <= 1'b0;
            end else if (clr_dr) begin
                xlda  <= 1'b0;
                gda   <= 1'b0;
                int_q <= 1'b0;
            end
        end
    end

`ifdef INERT_SERF_OVR_EN
    // Sticky: a new sample landed while the previous one was still flagged.
    always_ff @(posedge clk) begin
        if (rst)                 ovr <= 1'b0;
        else if (commit && int_q) ovr <= 1'b1;
        else if (clr_st)         ovr <= 1'b0;
    end
`else
    logic unused_clr_st;
    assign unused_clr_st = clr_st;
    assign ovr = 1'b0;
`endif

    assign spi.MISO = miso_q;
    assign spi.INT  = int_q;
    assign cfg_done = &wr_seen;
endmodule

// File: tb/tb_inert_spi_serf.sv
// Self-checking bench for inert_spi_serf: SPI frames are driven by tasks that
// push expected read bytes / pin levels into a scoreboard; a monitor pops and
// compares whenever a frame response or pin probe is presented.
module tb_inert_spi_serf;
    localparam int HP = 5;   // SCLK half-period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic smpl_vld = 1'b0;
    logic [15:0] roll_rt = '0, yaw_rt = '0, AY = '0, AZ = '0;
    logic cfg_done;

    inert_spi_serf_if bus();

    inert_spi_serf #(.WHOAMI(8'h6A), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi(bus), .smpl_vld(smpl_vld),
        .roll_rt(roll_rt), .yaw_rt(yaw_rt), .AY(AY), .AZ(AZ), .cfg_done(cfg_done));

    always #5 clk = ~clk;

    // Scoreboard: kind 0 = frame read byte, 1 = INT pin, 2 = cfg_done pin
    int          q_kind[$];
    logic [7:0]  q_exp[$];
    string       q_nm[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] resp_cap = '0;
    logic        resp_stb = 1'b0;
    logic        probe_stb = 1'b0;
    logic        final_stb = 1'b0;

    function automatic void push(input int k, input logic [7:0] e, input string nm);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_nm.push_back(nm);
    endfunction

    always @(negedge clk) begin
        int         k;
        logic [7:0] e, act;
        string      nm;
        if (resp_stb || probe_stb) begin
            if (q_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_underflow: output seen with nothing expected");
            end else begin
                k  = q_kind.pop_front();
                e  = q_exp.pop_front();
                nm = q_nm.pop_front();
                case (k)
                    0:       act = resp_cap[7:0];
                    1:       act = {7'd0, bus.INT};
                    default: act = {7'd0, cfg_done};
                endcase
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
        if (final_stb) begin
            n_cmp++;
            if (q_exp.size() != 0) begin
                n_bad++;
                $display("FAIL scoreboard_leftover: got %0d pending expected 0", q_exp.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame of nb bits; chk=0 for aborted frames (no response).
    task automatic spi_xfer(input logic [15:0] f, input int nb, input bit chk,
                            input logic [7:0] e, input string nm);
        logic [15:0] r = '0;
        if (chk) push(0, e, nm);
        bus.SS_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nb; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = f[15-i];
            repeat (HP) tick();
            bus.SCLK = 1'b1;
            r = {r[14:0], bus.MISO};
            repeat (HP) tick();
        end
        bus.SS_n = 1'b1;
        repeat (6) tick();
        if (chk) begin
            resp_cap  = r;
            resp_stb  = 1'b1;
            tick();
            resp_stb  = 1'b0;
        end
        tick();
    endtask

    task automatic rd(input logic [15:0] f, input logic [7:0] e, input string nm);
        spi_xfer(f, 16, 1'b1, e, nm);
    endtask

    task automatic wr(input logic [15:0] f);
        spi_xfer(f, 16, 1'b0, 8'h00, "");
    endtask

    task automatic probe(input int k, input logic [7:0] e, input string nm);
        push(k, e, nm);
        probe_stb = 1'b1;
        tick();
        probe_stb = 1'b0;
    endtask

    // Sample strobe with INT checked low during the strobe and high one clk later.
    task automatic sample_int_chk(input string nm);
        push(1, 8'h00, {nm, "_int_before"});
        smpl_vld  = 1'b1;
        probe_stb = 1'b1;
        tick();
        smpl_vld  = 1'b0;
        probe_stb = 1'b0;
        probe(1, 8'h01, {nm, "_int_after"});
    endtask

    task automatic pulse_smpl();
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset state and identity
        probe(1, 8'h00, "rst_int");
        probe(2, 8'h00, "rst_cfg_done");
        rd(16'h8F00, 8'h6A, "whoami");
        rd(16'h9E00, 8'h00, "rst_status");
        rd(16'h9000, 8'h00, "rst_ctrl1");

        // Config writes, cfg_done only after all four
        wr(16'h0D02); wr(16'h1053); wr(16'h1150);
        probe(2, 8'h00, "cfg_done_3of4");
        wr(16'h1460);
        probe(2, 8'h01, "cfg_done_4of4");
        rd(16'h9000, 8'h53, "ctrl1_xl");
        rd(16'h8D00, 8'h02, "int1_ctrl");
        rd(16'h9100, 8'h50, "ctrl2_g");
        rd(16'h9400, 8'h60, "ctrl5_c");
        wr(16'h0F55);
        rd(16'h8F00, 8'h6A, "whoami_ro");
        rd(16'hA800, 8'h00, "unmapped_28");
        wr(16'h1E07);
        rd(16'h9E00, 8'h00, "status_ro");

        // Sample capture and clear-on-read
        roll_rt = 16'h1234; yaw_rt = 16'hABCD; AY = 16'h0102; AZ = 16'hBEEF;
        sample_int_chk("smp1");
        rd(16'hA400, 8'h34, "roll_l");
        rd(16'hA500, 8'h12, "roll_h");
        rd(16'hA600, 8'hCD, "yaw_l");
        rd(16'hAB00, 8'h01, "ay_h");
        rd(16'hAC00, 8'hEF, "az_l");
        rd(16'h9E00, 8'h03, "status_dr");
        rd(16'hAD00, 8'hBE, "az_h");
        probe(1, 8'h00, "int_clr_2d");
        rd(16'h9E00, 8'h00, "status_clr");

        // Sample during a frame must not disturb that frame
        fork
            rd(16'hA400, 8'h34, "roll_l_midframe");
            begin
                repeat (20) tick();
                roll_rt = 16'h5555;
                pulse_smpl();
            end
        join
        probe(1, 8'h01, "int_pending_commit");
        rd(16'hA400, 8'h55, "roll_l_new");
        rd(16'hAD00, 8'hBE, "az_h_2");
        probe(1, 8'h00, "int_clr_2");

        // Aborted frames have no effect
        pulse_smpl();
        probe(1, 8'h01, "int_smp3");
        spi_xfer(16'h1000, 10, 1'b0, 8'h00, "");
        probe(1, 8'h01, "int_after_abort_wr");
        rd(16'h9000, 8'h53, "ctrl1_after_abort");
        spi_xfer(16'hAD00, 12, 1'b0, 8'h00, "");
        probe(1, 8'h01, "int_after_abort_rd");
        rd(16'h9E00, 8'h03, "status_after_abort");

        // Second sample while INT still high
        pulse_smpl();
`ifdef INERT_SERF_OVR_EN
        rd(16'h9E00, 8'h07, "status_ovr");
`else
        rd(16'h9E00, 8'h03, "status_ovr");
`endif
        rd(16'h9E00, 8'h03, "status_ovr_clr");
        rd(16'hAD00, 8'hBE, "az_h_3");
        probe(1, 8'h00, "int_clr_3");
        rd(16'h9E00, 8'h00, "status_final");

        repeat (5) tick();
        final_stb = 1'b1;
        tick();
        final_stb = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
